// File: rtl/if_queue_pkg.sv
// Shared widths and ISA defaults for the IF-stage instruction queue.
// The same constants are used by the IF and ID stages.
package if_queue_pkg;

  localparam int unsigned DEF_DEPTH  = 4;
  localparam int unsigned DEF_ADDR_W = 30;
  localparam int unsigned DEF_DATA_W = 32;

  // Word address fetched after reset, and the bubble instruction shown when empty.
  localparam logic [DEF_ADDR_W-1:0] DEF_RESET_VECTOR = '0;
  localparam logic [DEF_DATA_W-1:0] DEF_NOP_INSN     = '0;

endpackage

// File: rtl/if_fifo.sv
// Generic synchronous FIFO with a combinational head output and a single-cycle clear.
// Push and pop may both happen on a full FIFO in the same cycle.
module if_fifo
  import if_queue_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned WIDTH = DEF_ADDR_W + DEF_DATA_W,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic [WIDTH-1:0] entries [DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [WIDTH-1:0] entry_reg;
      always_ff @(posedge clk) begin
        if (push && wr_ptr_reg == PTR_W'(gi)) begin
          entry_reg <= din;
        end
      end
      assign entries[gi] = entry_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (push && !pop) begin
        count_reg <= count_reg + 1'b1;
      end else if (pop && !push) begin
        count_reg <= count_reg - 1'b1;
      end
    end
  end

  assign full  = (count_reg == (PTR_W+1)'(DEPTH));
  assign empty = (count_reg == '0);
  assign head  = entries[rd_ptr_reg];

endmodule

// File: rtl/if_queue.sv
// IF-stage instruction queue: owns the fetch PC, buffers fetched words with their PCs
// and presents the oldest one to ID, so fetch can run ahead while ID stalls.
module if_queue
  import if_queue_pkg::*;
#(
  parameter int unsigned           DEPTH        = DEF_DEPTH,
  parameter int unsigned           ADDR_W       = DEF_ADDR_W,
  parameter int unsigned           DATA_W       = DEF_DATA_W,
  parameter logic [ADDR_W-1:0]     RESET_VECTOR = ADDR_W'(DEF_RESET_VECTOR),
  parameter logic [DATA_W-1:0]     NOP_INSN     = DATA_W'(DEF_NOP_INSN)
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] fetch_pc,
  output logic              fetch_req,
  input  logic [DATA_W-1:0] insn,
  input  logic              insn_valid,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] new_pc,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_addr,
  output logic [ADDR_W-1:0] if_pc,
  output logic [DATA_W-1:0] if_insn,
  output logic              if_en
);

  localparam int unsigned WIDTH = ADDR_W + DATA_W;

  logic [ADDR_W-1:0] fetch_pc_reg;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_target;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic [WIDTH-1:0]  head;

  // flush outranks a taken branch when both arrive together.
  assign redirect        = flush | br_taken;
  assign redirect_target = flush ? new_pc : br_addr;

  // A pop frees its slot at the same edge, so a full queue can still accept a word.
  assign pop       = !empty && !stall && !redirect;
  assign fetch_req = !full || pop;
  assign push      = insn_valid && fetch_req && !redirect;

  if_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clr   (redirect),
    .push  (push),
    .pop   (pop),
    .din   ({fetch_pc_reg, insn}),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_reg <= RESET_VECTOR;
    end else if (redirect) begin
      fetch_pc_reg <= redirect_target;
    end else if (push) begin
      fetch_pc_reg <= fetch_pc_reg + 1'b1;
    end
  end

  assign fetch_pc = fetch_pc_reg;
  assign if_en    = !empty;
  assign if_insn  = empty ? NOP_INSN : head[DATA_W-1:0];
  assign if_pc    = empty ? fetch_pc_reg : head[WIDTH-1:DATA_W];

endmodule

// File: tb/tb_if_queue.sv
// Scoreboard bench for if_queue: the stimulus side predicts pushes, the monitor checks pops.
module tb_if_queue;

  localparam int          DEPTH = 4;
  localparam logic [29:0] RV    = 30'h100;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        insn_valid = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        br_taken = 1'b0;
  logic [29:0] new_pc = '0;
  logic [29:0] br_addr = '0;
  logic [31:0] insn = '0;
  logic [29:0] fetch_pc;
  logic        fetch_req;
  logic [29:0] if_pc;
  logic [31:0] if_insn;
  logic        if_en;

  if_queue #(
    .DEPTH        (DEPTH),
    .ADDR_W       (30),
    .DATA_W       (32),
    .RESET_VECTOR (RV),
    .NOP_INSN     (NOP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .fetch_pc   (fetch_pc),
    .fetch_req  (fetch_req),
    .insn       (insn),
    .insn_valid (insn_valid),
    .stall      (stall),
    .flush      (flush),
    .new_pc     (new_pc),
    .br_taken   (br_taken),
    .br_addr    (br_addr),
    .if_pc      (if_pc),
    .if_insn    (if_insn),
    .if_en      (if_en)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [61:0] sb [$];
  logic [29:0] m_pc = '0;
  int          m_cnt = 0;
  bit          model_ok = 1'b0;

  function automatic logic [31:0] insn_of(input logic [29:0] pc);
    return {2'b10, pc} ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock cycle of stimulus; predicted outputs are checked before the edge.
  task automatic step(input logic v, input logic s, input logic f, input logic [29:0] np,
                      input logic b, input logic [29:0] ba, input logic r);
    logic redir, exp_pop, exp_req, exp_push;
    @(negedge clk);
    insn_valid = v; stall = s; flush = f; new_pc = np;
    br_taken = b; br_addr = ba; reset = r;
    insn = insn_of(m_pc);
    #1;
    redir    = f | b;
    exp_pop  = (m_cnt > 0) && !s && !redir;
    exp_req  = (m_cnt < DEPTH) || exp_pop;
    exp_push = v && exp_req && !redir;
    if (model_ok) begin
      chk("fetch_pc", 64'(fetch_pc), 64'(m_pc));
      chk("fetch_req", 64'(fetch_req), 64'(exp_req));
      chk("if_en", 64'(if_en), 64'(m_cnt != 0));
      if (m_cnt == 0) begin
        chk("empty_insn", 64'(if_insn), 64'(NOP));
        chk("empty_pc", 64'(if_pc), 64'(m_pc));
      end
    end
    if (r) begin
      m_cnt = 0; m_pc = RV; sb.delete(); model_ok = 1'b1;
    end else if (redir) begin
      m_cnt = 0; m_pc = f ? np : ba; sb.delete();
    end else begin
      if (exp_push) begin
        sb.push_back({m_pc, insn_of(m_pc)});
        $display("push pc=%0h insn=%0h", m_pc, insn_of(m_pc));
        m_pc = m_pc + 30'd1;
      end
      m_cnt = m_cnt + int'(exp_push) - int'(exp_pop);
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: every head consumed by ID must match the oldest predicted entry.
  initial begin
    logic [61:0] exp_e;
    forever begin
      @(negedge clk);
      #2;
      if (if_en === 1'b1 && !stall && !flush && !br_taken && !reset) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL head_pop: got pop of pc %0h expected no entry", if_pc);
        end else begin
          exp_e = sb.pop_front();
          chk("head_pc", 64'(if_pc), 64'(exp_e[61:32]));
          chk("head_insn", 64'(if_insn), 64'(exp_e[31:0]));
          $display("pop  pc=%0h insn=%0h", if_pc, if_insn);
        end
      end
    end
  end

  initial begin
    // reset, then free run: heads 0x100, 0x101, 0x102
    step(0, 0, 0, '0, 0, '0, 1);
    step(0, 0, 0, '0, 0, '0, 1);
    for (int i = 0; i < 4; i++) step(1, 0, 0, '0, 0, '0, 0);

    // re-reset, then stall for 6 cycles while fetching
    step(0, 0, 0, '0, 0, '0, 1);
    for (int i = 0; i < 6; i++) step(1, 1, 0, '0, 0, '0, 0);
    chk("stall_fetch_pc", 64'(fetch_pc), 64'h104);
    chk("stall_fetch_req", 64'(fetch_req), 64'h0);
    chk("stall_head_pc", 64'(if_pc), 64'h100);

    // release: pop 0x100 and push 0x104 at the same edge
    step(1, 0, 0, '0, 0, '0, 0);
    chk("release_head_pc", 64'(if_pc), 64'h101);
    chk("release_fetch_pc", 64'(fetch_pc), 64'h105);
    chk("release_fetch_req", 64'(fetch_req), 64'h1);
    for (int i = 0; i < 3; i++) step(1, 0, 0, '0, 0, '0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, '0, 0, '0, 0);

    // taken branch with 3 entries queued while ID stalls
    for (int i = 0; i < 3; i++) step(1, 1, 0, '0, 0, '0, 0);
    step(0, 1, 0, '0, 1, 30'h200, 0);
    chk("br_fetch_pc", 64'(fetch_pc), 64'h200);
    chk("br_if_en", 64'(if_en), 64'h0);
    step(1, 1, 0, '0, 0, '0, 0);
    chk("br_head_en", 64'(if_en), 64'h1);
    chk("br_head_pc", 64'(if_pc), 64'h200);

    // flush and branch together: flush target wins
    step(1, 0, 1, 30'h300, 1, 30'h200, 0);
    chk("flush_fetch_pc", 64'(fetch_pc), 64'h300);
    chk("flush_if_en", 64'(if_en), 64'h0);

    // insn_valid toggling with no stall
    for (int i = 0; i < 6; i++) step(((i % 2) == 0), 0, 0, '0, 0, '0, 0);

    // reset mid-stream with 3 entries queued
    for (int i = 0; i < 3; i++) step(1, 1, 0, '0, 0, '0, 0);
    step(1, 1, 0, '0, 0, '0, 1);
    chk("rst_if_en", 64'(if_en), 64'h0);
    chk("rst_fetch_pc", 64'(fetch_pc), 64'h100);
    chk("rst_if_insn", 64'(if_insn), 64'(NOP));

    // short run after reset, then drain and confirm nothing is left over
    for (int i = 0; i < 3; i++) step(1, 0, 0, '0, 0, '0, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, '0, 0, '0, 0);
    chk("sb_drained", 64'(sb.size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_queue.md
# if_queue

Parametrised IF-stage instruction queue, the next generation of the single-entry IF/ID pipeline register. It owns the fetch program counter and captures each fetched word with its PC into a DEPTH-entry FIFO. It presents the oldest entry to the ID stage, which lets fetch run ahead while ID stalls. It sits between the instruction memory/bus interface and the ID stage, and takes redirects (flush, taken branch) from the pipeline control unit.

## Interface
- DEPTH, 4: queue entries; power of two, ≥2
- ADDR_W, 30: word-address width
- DATA_W, 32: instruction width
- RESET_VECTOR, 0: fetch PC after reset
- NOP_INSN, 0: instruction value presented when the queue is empty
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high reset
- fetch_pc  out  ADDR_W  word address of the current fetch request (registered)
- fetch_req  out  1  fetch request; 1 whenever the queue can accept a word this cycle
- insn  in  DATA_W  fetched word for fetch_pc, same cycle
- insn_valid  in  1  insn is valid this cycle (bus/memory ready)
- stall  in  1  ID cannot consume the head entry this cycle
- flush  in  1  discard all entries, redirect to new_pc
- new_pc  in  ADDR_W  flush target
- br_taken  in  1  discard all entries, redirect to br_addr
- br_addr  in  ADDR_W  branch target
- if_pc  out  ADDR_W  PC of the head entry
- if_insn  out  DATA_W  instruction of the head entry; NOP_INSN when empty
- if_en  out  1  head entry valid (queue non-empty)

## Operation
- Reset: the queue is emptied (count=0, both pointers 0) and fetch_pc=RESET_VECTOR. Resulting outputs: fetch_req=1, if_en=0, if_insn=NOP_INSN, if_pc=RESET_VECTOR.
- redirect = flush | br_taken. flush has priority: the target is new_pc if flush=1, otherwise br_addr.
- A redirect acts regardless of stall. At the edge, all entries are discarded (count=0, pointers reset) and fetch_pc takes the target value. No push or pop happens in that cycle.
- push = insn_valid & fetch_req & !redirect. It writes {fetch_pc, insn} at the write pointer and increments fetch_pc by 1, wrapping modulo 2^ADDR_W.
- pop = if_en & !stall & !redirect. It advances the read pointer.
- fetch_req = (count < DEPTH) | pop. A full queue still accepts a push in the same cycle as a pop.
- count update: +1 for push only, -1 for pop only, unchanged for both or neither.
- Pointers are log2(DEPTH) bits wide and wrap naturally. count is log2(DEPTH)+1 bits wide.
- The head outputs are driven from the storage registers at the read pointer. When count=0: if_en=0, if_insn=NOP_INSN, if_pc=fetch_pc.
- reset overrides redirect, push and pop in the same cycle.

## Timing
- The word fetched at cycle N appears at the head at N+1 if the queue was empty (1-cycle latency). Otherwise it appears after all older entries have popped.
- Redirect at edge N: the target is presented on fetch_pc during cycle N+1 and pushed at the end of N+1. The target is at the head (if_en=1) in cycle N+2, giving exactly one bubble cycle.
- With insn_valid=1 every cycle and stall=0, throughput is 1 entry/cycle and count stays at 1.
- With stall held, the queue fills to DEPTH in DEPTH cycles. After that, fetch_req=0 and fetch_pc holds.
- The first pop after a long stall frees space at that same edge, so fetch resumes with no dead cycle.

## Structure
- NOP_INSN and RESET_VECTOR defaults come from the ISA opcode definitions. Widths come from the shared CPU/global header constants, which this block shares with the IF/ID stages.
- Sub-module if_fifo provides generic synchronous FIFO storage: parameters DEPTH and WIDTH=ADDR_W+DATA_W; ports push, pop, clr, full, empty, head.
- if_queue keeps the fetch PC, the redirect priority, the fetch_req logic and the empty-queue output muxing.

## Test plan
- Reset then free-run with DEPTH=4 and RESET_VECTOR=0x100: if_pc=0x100,0x101,0x102 on consecutive cycles from cycle 2, with if_en=1 continuously.
- stall=1 for 6 cycles while insn_valid=1: count reaches 4 and fetch_req=0. fetch_pc holds at 0x104, the head holds 0x100, and no entry is lost or duplicated after release.
- Full queue, then stall=0: at the same edge, pop of 0x100 and push of 0x104 occur; count stays 4.
- br_taken=1 with br_addr=0x200 while 3 entries are queued and stall=1: next cycle if_en=0 and fetch_pc=0x200; the following cycle if_pc=0x200.
- flush=1 (new_pc=0x300) together with br_taken=1 (br_addr=0x200): the redirect goes to 0x300.
- insn_valid toggling 1/0 with stall=0: if_en toggles accordingly, and fetch_pc advances only on valid cycles.
- reset asserted mid-stream with count=3: next cycle count=0, if_en=0, fetch_pc=RESET_VECTOR.
